// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles the two writeback requesters, the register-file write port and
//   the status outputs of regfile_wb_arbiter.
//
//   Requester A (ALU/execute) : a_valid, a_addr, a_data -> a_ready
//   Requester B (memory load) : b_valid, b_addr, b_data -> b_ready
//   Register-file write port  : WE3, WA3, WD3 (registered, commit on negedge)
//   Status                    : busy (CLEAR sweep running), stall_cnt
//
//   modport slave  : the arbiter side
//   modport master : the requester / register-file side
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int ADDR_SIZE  = 5,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) ();
   logic                  a_valid;
   logic [ADDR_SIZE-1:0]  a_addr;
   logic [DATA_WIDTH-1:0] a_data;
   logic                  a_ready;

   logic                  b_valid;
   logic [ADDR_SIZE-1:0]  b_addr;
   logic [DATA_WIDTH-1:0] b_data;
   logic                  b_ready;

   logic                  WE3;
   logic [ADDR_SIZE-1:0]  WA3;
   logic [DATA_WIDTH-1:0] WD3;

   logic                  busy;
   logic [CNT_WIDTH-1:0]  stall_cnt;

   modport slave (
      input  a_valid, a_addr, a_data,
      output a_ready,
      input  b_valid, b_addr, b_data,
      output b_ready,
      output WE3, WA3, WD3,
      output busy, stall_cnt
   );

   modport master (
      output a_valid, a_addr, a_data,
      input  a_ready,
      output b_valid, b_addr, b_data,
      input  b_ready,
      input  WE3, WA3, WD3,
      input  busy, stall_cnt
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Owns the single register-file write port (WE3/WA3/WD3) of the multicycle
//   MIPS core. After reset it sweeps registers 1..2**ADDR_SIZE-1 to zero, then
//   each cycle grants the port to one of two writeback requesters:
//     A = ALU/execute writeback, B = memory-load writeback.
//   Write-port outputs are registered on posedge CLK so they are stable when
//   the register file commits on the following negedge.
//
// Ports
//   CLK  : core clock, all state changes on posedge
//   rst  : asynchronous, active-high reset
//   bus  : regfile_wb_arbiter_if.slave
//          a_*/b_* valid/ready requester handshakes (ready is combinational),
//          WE3/WA3/WD3 write port, busy (sweep running), stall_cnt
//          (saturating count of RUN cycles with an ungranted valid request)
//
// Configuration
//   RFARB_ROUND_ROBIN_EN : when defined, a tie goes to the requester that was
//                          not granted last (first tie after reset goes to A).
//                          When undefined, A always wins a tie.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int ADDR_SIZE  = 5,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input logic                 CLK,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_SIZE-1:0] FIRST_CLR = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   state_t                state_q, state_d;
   logic [ADDR_SIZE-1:0]  clr_addr_q, clr_addr_d;
   logic                  we_q, we_d;
   logic [ADDR_SIZE-1:0]  wa_q, wa_d;
   logic [DATA_WIDTH-1:0] wd_q, wd_d;
   logic                  busy_q, busy_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

   logic gnt_a, gnt_b;
   logic tie_to_a;   // who wins when both requesters are valid
   logic stall;

`ifdef RFARB_ROUND_ROBIN_EN
   // 1 = last handshake went to B. Resets to B so the first tie goes to A.
   logic last_b_q, last_b_d;

   assign tie_to_a = last_b_q;

   always_comb begin
      last_b_d = last_b_q;
      if (gnt_a && bus.a_valid) begin
         last_b_d = 1'b0;
      end else if (gnt_b && bus.b_valid) begin
         last_b_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         last_b_q <= 1'b1;
      end else begin
         last_b_q <= last_b_d;
      end
   end
`else
   assign tie_to_a = 1'b1;
`endif

   // -----------------------------------------------------------------------
   // Grant: only in RUN. A lone valid requester always wins; a tie is
   // resolved by tie_to_a. While rst is high state_q is CLEAR, so both
   // readies are held low.
   // -----------------------------------------------------------------------
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (state_q == RUN) begin
         if (bus.a_valid && bus.b_valid) begin
            gnt_a = tie_to_a;
            gnt_b = !tie_to_a;
         end else begin
            gnt_a = bus.a_valid;
            gnt_b = bus.b_valid;
         end
      end
   end

   assign bus.a_ready = gnt_a;
   assign bus.b_ready = gnt_b;

   // A valid request that was not granted this RUN cycle. Requests held
   // during the CLEAR sweep are not stalls.
   assign stall = (state_q == RUN) &&
                  ((bus.a_valid && !gnt_a) || (bus.b_valid && !gnt_b));

   // -----------------------------------------------------------------------
   // Next state / write-port issue
   // -----------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      we_d        = 1'b0;
      wa_d        = wa_q;
      wd_d        = wd_q;
      busy_d      = busy_q;
      stall_cnt_d = stall_cnt_q;

      case (state_q)
         CLEAR: begin
            // Register 0 is skipped: the sweep starts at 1 and ends at the
            // top address, 2**ADDR_SIZE-1 cycles in total.
            we_d       = 1'b1;
            wa_d       = clr_addr_q;
            wd_d       = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
               state_d = RUN;
               busy_d  = 1'b0;
            end
         end

         RUN: begin
            if (gnt_a) begin
               wa_d = bus.a_addr;
               wd_d = bus.a_data;
               // $0 is hardwired: the handshake completes but no write issues.
               we_d = (bus.a_addr != '0);
            end else if (gnt_b) begin
               wa_d = bus.b_addr;
               wd_d = bus.b_data;
               we_d = (bus.b_addr != '0);
            end
            if (stall && (stall_cnt_q != CNT_MAX)) begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // State registers. Reset drops any in-flight write (WE3 low at once) and
   // restarts the sweep from register 1.
   // -----------------------------------------------------------------------
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q     <= CLEAR;
         clr_addr_q  <= FIRST_CLR;
         we_q        <= 1'b0;
         wa_q        <= '0;
         wd_q        <= '0;
         busy_q      <= 1'b1;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         we_q        <= we_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
         busy_q      <= busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.WE3       = we_q;
   assign bus.WA3       = wa_q;
   assign bus.WD3       = wd_q;
   assign bus.busy      = busy_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule
